// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED playback controller.
// Holds the controller state encoding, playback mode codes and default widths.
package led_seq_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DIV_W  = 24;

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: control/config inputs and address outputs of the playback
// controller. The master side drives go/stop/pause/step and the window; the
// slave side (the controller) returns the address stream and status pulses.
interface led_seq_ctrl_if
    import led_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV_W  = DEF_DIV_W
) ();

    logic              go;
    logic              stop;
    logic              pause;
    logic              step;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [DIV_W-1:0]  div_val;
    logic [ADDR_W-1:0] addr_out;
    logic              addr_stb;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output go, stop, pause, step, mode, start_addr, end_addr, div_val,
        input  addr_out, addr_stb, busy, done, err
    );

    modport slave (
        input  go, stop, pause, step, mode, start_addr, end_addr, div_val,
        output addr_out, addr_stb, busy, done, err
    );

endinterface

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: loadable dwell down-counter. While not frozen it counts
// down; the cycle it sits at zero it raises tick and reloads from load_val.
// An explicit load overrides everything, and freeze holds the count.
module led_seq_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             freeze,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = !freeze && (cnt_q == '0);

    // Count register: load, reload on tick, otherwise decrement unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load || tick) begin
            cnt_q <= load_val;
        end else if (!freeze) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequenced address source for the LED pattern memory.
// Plays the window start_addr..end_addr in loop, single-shot or ping-pong
// order with a programmable dwell, under run/pause/step/stop control.
// Build option: define LED_SEQ_PINGPONG_EN to enable ping-pong playback;
// without it the direction logic is absent and mode 2'b10 plays as loop.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input logic           clk,
    input logic           rst_n,
    led_seq_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, adv_addr;
    logic [ADDR_W-1:0] start_sh, end_sh;
    logic [DIV_W-1:0]  div_sh, pre_val;
    logic [1:0]        mode_sh;
    logic              stb_q, stb_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              load_sh, pre_load, run_en, tick, adv_fin, do_adv;
`ifdef LED_SEQ_PINGPONG_EN
    logic              dir_q, dir_d, adv_dir;  // 1 = walking down the window
`endif

    // The dwell counter only runs in RUN; stop and a rising pause swallow the tick.
    assign run_en = (state_q == ST_RUN) && !bus.stop && !bus.pause;

    led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pre_load),
        .freeze   (!run_en),
        .load_val (pre_val),
        .tick     (tick)
    );

    // Next address in playback order, and whether single-shot has finished.
    always_comb begin
        adv_addr = addr_q + 1'b1;
        adv_fin  = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
        adv_dir  = dir_q;
        if (mode_sh == MODE_PINGPONG) begin
            if (start_sh == end_sh) begin
                adv_addr = addr_q;
            end else if (!dir_q) begin
                if (addr_q == end_sh) begin
                    adv_addr = addr_q - 1'b1;
                    adv_dir  = 1'b1;
                end
            end else if (addr_q == start_sh) begin
                adv_dir = 1'b0;
            end else begin
                adv_addr = addr_q - 1'b1;
            end
        end else
`endif
        if (mode_sh == MODE_ONESHOT) begin
            adv_fin = (addr_q == end_sh);
        end else if (addr_q == end_sh) begin
            adv_addr = start_sh;
        end
    end

    // Control FSM: stop > go > pause > step > tick.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load_sh  = 1'b0;
        pre_load = 1'b0;
        pre_val  = div_sh;
        do_adv   = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
        dir_d    = dir_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.go) begin
                    if (bus.start_addr <= bus.end_addr) begin
                        state_d  = ST_RUN;
                        addr_d   = bus.start_addr;
                        stb_d    = 1'b1;
                        load_sh  = 1'b1;
                        pre_load = 1'b1;
                        pre_val  = bus.div_val;
`ifdef LED_SEQ_PINGPONG_EN
                        dir_d    = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop)       state_d = ST_IDLE;
                else if (bus.pause) state_d = ST_PAUSE;
                else if (tick)      do_adv  = 1'b1;
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end else if (bus.step) begin
                    do_adv   = 1'b1;
                    pre_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_adv) begin
            if (adv_fin) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                addr_d = adv_addr;
                stb_d  = 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
                dir_d  = adv_dir;
`endif
            end
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shadow copy of the playback configuration, taken on an accepted go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sh <= '0;
            end_sh   <= '0;
            div_sh   <= '0;
            mode_sh  <= MODE_LOOP;
        end else if (load_sh) begin
            start_sh <= bus.start_addr;
            end_sh   <= bus.end_addr;
            div_sh   <= bus.div_val;
            mode_sh  <= bus.mode;
        end
    end

`ifdef LED_SEQ_PINGPONG_EN
    // Ping-pong direction; starts upward on every accepted go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dir_q <= 1'b0;
        else        dir_q <= dir_d;
    end
`endif

    assign bus.addr_out = addr_q;
    assign bus.addr_stb = stb_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scoreboard bench for led_seq_ctrl. Expected strobe, done,
// err and busy events come from a reference model that derives addresses
// from the playback index and timing from the next-strobe cycle.
// Honours LED_SEQ_PINGPONG_EN the same way the design does.
module tb_led_seq_ctrl;

    localparam int AW = 3;
    localparam int DW = 24;

    localparam int K_ERR = 0, K_STB = 1, K_DONE = 2, K_BUSY = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    bit   prev_busy = 1'b0;

    // reference model state
    int m_st = M_IDLE;
    int m_mode, m_s, m_e, m_d, m_idx, m_next, m_rem;
    // configuration presented on the inputs
    int c_mode, c_s, c_e, c_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_seq_ctrl_if #(.ADDR_W(AW), .DIV_W(DW)) bus ();

    led_seq_ctrl #(.ADDR_W(AW), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic string kname(int k);
        case (k)
            K_ERR:   return "err";
            K_STB:   return "strobe";
            K_DONE:  return "done";
            default: return "busy";
        endcase
    endfunction

    task automatic chk(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int addr_of(int idx);
        int len, period, p;
        len = m_e - m_s + 1;
        if (m_mode == 1) return m_s + idx;
`ifdef LED_SEQ_PINGPONG_EN
        if (m_mode == 2 && len > 1) begin
            period = 2 * (len - 1);
            p = idx % period;
            return (p < len) ? m_s + p : m_s + period - p;
        end
`endif
        return m_s + (idx % len);
    endfunction

    task automatic push(int k, int c, int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic advance(int c);
        m_idx++;
        if (m_mode == 1 && m_idx == m_e - m_s + 1) begin
            push(K_DONE, c + 1, m_e);
            m_st = M_DONE;
        end else begin
            push(K_STB, c + 1, addr_of(m_idx));
            m_next = c + 2 + m_d;
        end
    endtask

    // Inputs applied during cycle c produce outputs visible in cycle c+1.
    task automatic model(int c, bit g, bit sp, bit pa, bit st);
        bit was_busy, now_busy;
        was_busy = (m_st == M_RUN) || (m_st == M_PAUSE);
        if (sp) begin
            m_st = M_IDLE;
        end else if (g && (m_st == M_IDLE || m_st == M_DONE)) begin
            if (c_s > c_e) begin
                push(K_ERR, c + 1, 0);
            end else begin
                m_mode = c_mode; m_s = c_s; m_e = c_e; m_d = c_d;
                m_idx  = 0;
                push(K_STB, c + 1, m_s);
                m_next = c + 2 + m_d;
                m_st   = M_RUN;
            end
        end else if (m_st == M_RUN) begin
            if (pa) begin
                m_st  = M_PAUSE;
                m_rem = m_next - c;
            end else if (m_next == c + 1) begin
                advance(c);
            end
        end else if (m_st == M_PAUSE) begin
            if (!pa) begin
                m_st   = M_RUN;
                m_next = c + 1 + m_rem;
            end else if (st) begin
                advance(c);
                m_rem = m_d + 1;
            end
        end
        now_busy = (m_st == M_RUN) || (m_st == M_PAUSE);
        if (now_busy != was_busy) push(K_BUSY, c + 1, int'(now_busy));
    endtask

    // ---------------- monitor ----------------
    task automatic observe(int k, int v);
        ev_t e;
        if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s: got val=%0d at cycle %0d, want no event", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.kind != k || e.val != v) begin
                n_bad++;
                $display("FAIL %s: got %s val=%0d at cycle %0d, want %s val=%0d", kname(e.kind),
                         kname(k), v, cyc, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic flush_missing(int upto);
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < upto) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_%s: got nothing, want val=%0d at cycle %0d", kname(e.kind), e.val, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            flush_missing(cyc);
            if (bus.err)      observe(K_ERR, 0);
            if (bus.addr_stb) observe(K_STB, int'(bus.addr_out));
            if (bus.done)     observe(K_DONE, int'(bus.addr_out));
            if (bus.busy !== prev_busy) begin
                observe(K_BUSY, int'(bus.busy));
                prev_busy = bus.busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit g, bit sp, bit pa, bit st);
        @(negedge clk);
        #1;
        bus.go         = g;
        bus.stop       = sp;
        bus.pause      = pa;
        bus.step       = st;
        bus.mode       = 2'(c_mode);
        bus.start_addr = AW'(c_s);
        bus.end_addr   = AW'(c_e);
        bus.div_val    = DW'(c_d);
        model(cyc, g, sp, pa, st);
    endtask

    task automatic set_cfg(int md, int s, int e, int d);
        c_mode = md; c_s = s; c_e = e; c_d = d;
    endtask

    task automatic rand_cfg();
        c_mode = $urandom_range(0, 3);
        c_s    = $urandom_range(0, 7);
        c_e    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(c_s, 7);
        c_d    = $urandom_range(0, 3);
    endtask

    task automatic idle(int n, bit pa);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, pa, 1'b0);
    endtask

    task automatic chk_outputs_reset(string tag);
        chk({tag, "_addr_out"}, int'(bus.addr_out), 0);
        chk({tag, "_addr_stb"}, int'(bus.addr_stb), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
    endtask

    initial begin
        bit pl;
        int n;
        bus.go = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.step = 1'b0;
        bus.mode = 2'b00; bus.start_addr = '0; bus.end_addr = '0; bus.div_val = '0;
        set_cfg(0, 0, 0, 0);
        #2;
        chk_outputs_reset("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // loop 1..3, dwell 3 cycles
        set_cfg(0, 1, 3, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // single-shot 0..2, advance every cycle
        set_cfg(1, 0, 2, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);
        chk("oneshot_hold_addr", int'(bus.addr_out), 2);
        chk("oneshot_idle_busy", int'(bus.busy), 0);

        // ping-pong 2..4 (plays as loop when the option is off)
        set_cfg(2, 2, 4, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(7, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // pause mid-dwell, three steps, release; then a plain pause/release
        set_cfg(0, 0, 7, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(9, 1'b0);
        idle(6, 1'b1);
        idle(14, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);

        // rejected window, then stop+go together while running
        set_cfg(0, 5, 2, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("err_state_idle_busy", int'(bus.busy), 0);
        set_cfg(0, 1, 6, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // asynchronous reset while running
        set_cfg(0, 3, 6, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outputs_reset("async_rst");
        flush_missing(cyc + 1);
        exp_q.delete();
        m_st = M_IDLE;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);

        // randomized sessions with config churn, pauses, steps and stray go
        for (int t = 0; t < 30; t++) begin
            pl = 1'b0;
            rand_cfg();
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n = $urandom_range(10, 40);
            for (int k = 0; k < n; k++) begin
                rand_cfg();
                if ($urandom_range(0, 7) == 0) pl = !pl;
                drive($urandom_range(0, 15) == 0, 1'b0, pl, $urandom_range(0, 3) == 0);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0);
        end

        idle(4, 1'b0);
        flush_missing(cyc + 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Playback controller for the LED pattern datapath. It replaces the free-running enable and address counter with a sequenced address source for the pattern memory. The block holds a programmable dwell prescaler, a start/end address window, a playback mode (loop, single-shot, ping-pong) and run/pause/step/stop control. The memory consumes `addr_out`; `addr_stb` marks each new address.

## Interface
- `ADDR_W`, default 3: pattern-memory address width.
- `DIV_W`, default 24: dwell prescaler width.
- `clk`  in  1: single system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `go`  in  1: start pulse. Latches `start_addr`, `end_addr`, `div_val` and `mode` into shadow registers.
- `stop`  in  1: abort pulse; the block returns to IDLE.
- `pause`  in  1: level input; freezes playback while high.
- `step`  in  1: pulse; advances one address while paused.
- `mode`  in  2: 00 loop, 01 single-shot, 10 ping-pong, 11 reserved (treated as loop).
- `start_addr`, `end_addr`  in  ADDR_W each: playback window, inclusive.
- `div_val`  in  DIV_W: dwell per address is `div_val+1` clk cycles.
- `addr_out`  out  ADDR_W: current pattern address.
- `addr_stb`  out  1: one-cycle pulse when `addr_out` takes a new value.
- `busy`  out  1: high in RUN or PAUSE.
- `done`  out  1: one-cycle pulse when a single-shot sequence completes.
- `err`  out  1: one-cycle pulse when `go` is rejected because `start_addr > end_addr`.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Reset values: `addr_out`=0, `addr_stb`=0, `busy`=0, `done`=0, `err`=0, direction=up, prescaler=0.
- IDLE or DONE, `go` with a valid window: go to RUN, `addr_out`←`start_addr`, strobe, prescaler←`div_val`, direction=up.
- `go` with an invalid window: pulse `err` and stay in the current state.
- `go` in RUN or PAUSE is ignored. Shadow registers change only on an accepted `go`.
- RUN: prescaler decrements each cycle. On reaching 0 (the tick) it reloads and the address advances by one with a strobe.
- Advance at the window boundary, by mode:
  - loop: `end_addr` → `start_addr`.
  - single-shot: the tick at `end_addr` moves to DONE, pulses `done`, holds `addr_out`, no strobe.
  - ping-pong: direction reverses at either end, so the boundary address is not repeated.
- `start_addr == end_addr`: loop and ping-pong re-strobe the same address every tick. Single-shot completes on the first tick.
- RUN with `pause`=1: go to PAUSE, prescaler frozen. `pause`=0 returns to RUN and the count continues where it stopped.
- `step` in PAUSE: advances one address with the same boundary rules. The prescaler reloads. A single-shot step at `end_addr` goes to DONE.
- `step` outside PAUSE is ignored.
- `stop` in any state: go to IDLE, `addr_out` held, no strobe.
- Priority in one cycle: `stop` > `go` > `pause` > `step` > tick. A tick in the cycle `pause` rises is suppressed.
- `rst_n` low mid-sequence forces all reset values immediately, asynchronously.

## Timing
- `go` at cycle N: RUN, `addr_out`=start and `addr_stb`=1 at N+1.
- Next strobe at N+2+`div_val`; strobes are then every `div_val+1` cycles. `div_val`=0 advances every cycle.
- `step` at cycle N: new address and strobe at N+1.
- `done` asserts the cycle after the final tick and is high for exactly 1 cycle.
- `err` asserts the cycle after the rejected `go`.
- `busy` is registered and changes together with the state.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- `LED_SEQ_PINGPONG_EN` defined: mode 10 is ping-pong as specified.
- Not defined: direction logic is removed and mode 10 behaves as loop.

## Structure
- Shared package `led_seq_pkg`:
  - state enum (IDLE/RUN/PAUSE/DONE);
  - mode encodings `MODE_LOOP`, `MODE_ONESHOT`, `MODE_PINGPONG`;
  - default `ADDR_W` and `DIV_W`.
- One sub-module, `led_seq_prescaler`: loadable down-counter with freeze input; outputs the tick.

## Test plan
- Reset with `div_val`=2, loop mode, window 1..3: strobes at addresses 1,2,3,1 every 3 cycles; first strobe 1 cycle after `go`.
- Single-shot, window 0..2, `div_val`=0: addresses 0,1,2; `done` 1 cycle after the tick at 2; state DONE; `addr_out`=2.
- Ping-pong (macro defined), window 2..4: 2,3,4,3,2,3. Rebuilt without the macro: 2,3,4,2.
- `pause` held 10 cycles mid-dwell, then 3 `step` pulses: no strobes while paused except 1 per step; after release, remaining dwell completes with no reload.
- `go` with start=5, end=2: `err` pulses, state stays IDLE. Then `stop` and `go` in the same cycle during RUN: IDLE, no strobe.
- `rst_n` pulsed low in RUN: all outputs at reset values asynchronously; with `rst_n` high again, no activity until the next `go`.
